// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - pipelined shift/rotate with valid/ready, one stage per shift bit
// Rotate mode (i_mode = 10) is built only when BARREL_SHIFTER_PIPE_ROTATE_EN is defined.
module barrel_shifter_pipe #(
    parameter int BW_DATA = 8,
    parameter int BW_TAG  = 4,
    localparam int BW_K   = $clog2(BW_DATA)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_K-1:0]    i_k,
    input  logic               i_left,
    input  logic [1:0]         i_mode,
    input  logic [BW_TAG-1:0]  i_tag,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BW_DATA-1:0] o_y,
    output logic [BW_TAG-1:0]  o_tag
);

    logic [BW_DATA-1:0] data_q [BW_K];
    logic [BW_K-1:0]    k_q    [BW_K];
    logic [1:0]         mode_q [BW_K];
    logic [BW_TAG-1:0]  tag_q  [BW_K];
    logic [BW_K-1:0]    left_q;
    logic [BW_K-1:0]    valid_q;

    logic [BW_DATA-1:0] src_d    [BW_K];
    logic [BW_DATA-1:0] nxt_d    [BW_K];
    logic [BW_K-1:0]    src_k    [BW_K];
    logic [1:0]         src_mode [BW_K];
    logic [BW_TAG-1:0]  src_tag  [BW_K];
    logic [BW_K-1:0]    src_left;
    logic [BW_K-1:0]    src_v;
    logic [BW_K-1:0]    can_load;

    // Arithmetic right relies on the data MSB still being the original sign,
    // which holds because every earlier stage either passed or sign-filled it.
    function automatic logic [BW_DATA-1:0] stage_op(
        input logic [BW_DATA-1:0] d,
        input logic               left,
        input logic [1:0]         mode,
        input int                 sh
    );
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
        if (mode == 2'b10) begin
            if (left)
                return (d << sh) | (d >> (BW_DATA - sh));
            else
                return (d >> sh) | (d << (BW_DATA - sh));
        end
`endif
        if (left)
            return d << sh;
        else if (mode == 2'b01)
            return $signed(d) >>> sh;
        else
            return d >> sh;
    endfunction

    always_comb begin
        src_d[0]    = i_a;
        src_k[0]    = i_k;
        src_left[0] = i_left;
        src_mode[0] = i_mode;
        src_tag[0]  = i_tag;
        src_v[0]    = i_valid;
        for (int s = 1; s < BW_K; s++) begin
            src_d[s]    = data_q[s-1];
            src_k[s]    = k_q[s-1];
            src_left[s] = left_q[s-1];
            src_mode[s] = mode_q[s-1];
            src_tag[s]  = tag_q[s-1];
            src_v[s]    = valid_q[s-1];
        end
        for (int s = 0; s < BW_K; s++) begin
            nxt_d[s] = src_k[s][s] ? stage_op(src_d[s], src_left[s], src_mode[s], 1 << s)
                                   : src_d[s];
        end
        // Ready chain: a stage may load when empty or when its contents move on.
        can_load[BW_K-1] = !valid_q[BW_K-1] || i_ready;
        for (int s = BW_K - 2; s >= 0; s--) begin
            can_load[s] = !valid_q[s] || can_load[s+1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
        end else begin
            for (int s = 0; s < BW_K; s++) begin
                if (can_load[s])
                    valid_q[s] <= src_v[s];
            end
        end
        for (int s = 0; s < BW_K; s++) begin
            if (can_load[s] && src_v[s]) begin
                data_q[s] <= nxt_d[s];
                k_q[s]    <= src_k[s];
                left_q[s] <= src_left[s];
                mode_q[s] <= src_mode[s];
                tag_q[s]  <= src_tag[s];
            end
        end
    end

    assign o_ready = can_load[0] && !i_rst;
    assign o_valid = valid_q[BW_K-1];
    assign o_y     = data_q[BW_K-1];
    assign o_tag   = tag_q[BW_K-1];

endmodule
